// File: rtl/bus_arbiter_if.sv
// Shared-bus handshake bundle: requester side (master) and arbiter side (slave).
interface bus_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         lock;
    logic [2*NREQ-1:0]       dst;
    logic [NREQ-1:0]         xfer_en;
    logic [3:0]              load_en;
    logic [NREQ-1:0]         ack;
    logic [$clog2(NREQ)-1:0] owner;
    logic                    busy;

    modport master (
        output req, lock, dst,
        input  xfer_en, load_en, ack, owner, busy
    );

    modport slave (
        input  req, lock, dst,
        output xfer_en, load_en, ack, owner, busy
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner of a shared tristate data bus: grant -> DRIVE -> LOAD,
// with bounded back-to-back bursts for a requester holding lock.
module bus_arbiter #(
    parameter int NREQ     = 4,
    parameter int LOCK_MAX = 3
) (
    input logic          clk,
    input logic          reset,
    bus_arbiter_if.slave bus
);
    localparam int IW = $clog2(NREQ);
    localparam int DW = 2;
    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;
    typedef struct packed {
        logic          found;
        logic [IW-1:0] idx;
    } pick_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] rel_ptr;
    logic [DW-1:0] dsel_q, dsel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    pick_t         idle_pick, rel_pick;
    logic          keep;

    // Lowest offset from start wins; the loop runs backwards so the last hit is the winner.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] start);
        pick_t p;
        int    j;
        p = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(start) + k) % NREQ;
            if (r[j]) begin
                p.found = 1'b1;
                p.idx   = IW'(j);
            end
        end
        return p;
    endfunction

    function automatic logic [DW-1:0] dst_of(input logic [2*NREQ-1:0] d, input logic [IW-1:0] i);
        return d[DW*i +: DW];
    endfunction

    assign rel_ptr   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign idle_pick = rr_pick(bus.req, ptr_q);
    assign rel_pick  = rr_pick(bus.req, rel_ptr);
    // cnt_q counts extra transfers already taken in this burst, so it stops at LOCK_MAX-1.
    assign keep      = bus.lock[owner_q] && bus.req[owner_q] && (cnt_q < CW'(LOCK_MAX - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            dsel_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            dsel_q  <= dsel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        dsel_d  = dsel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (idle_pick.found) begin
                    state_d = DRIVE;
                    owner_d = idle_pick.idx;
                    dsel_d  = dst_of(bus.dst, idle_pick.idx);
                    cnt_d   = '0;
                end
            end
            DRIVE: state_d = LOAD;
            LOAD: begin
                if (keep) begin
                    state_d = DRIVE;
                    dsel_d  = dst_of(bus.dst, owner_q);
                    cnt_d   = cnt_q + 1'b1;
                end else begin
                    // Released owner drops to lowest priority for the immediate re-arbitration.
                    cnt_d = '0;
                    ptr_d = rel_ptr;
                    if (rel_pick.found) begin
                        state_d = DRIVE;
                        owner_d = rel_pick.idx;
                        dsel_d  = dst_of(bus.dst, rel_pick.idx);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only flops, so reset clears the bus at once and req never reaches xfer_en.
    always_comb begin
        bus.xfer_en = '0;
        bus.load_en = '0;
        bus.ack     = '0;
        bus.busy    = (state_q != IDLE);
        bus.owner   = owner_q;
        if (state_q != IDLE) bus.xfer_en[owner_q] = 1'b1;
        if (state_q == LOAD) begin
            bus.load_en[dsel_q] = 1'b1;
            bus.ack[owner_q]    = 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic against a transfer-level model.
module tb_bus_arbiter;
    localparam int LOCK_MAX = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;

    bus_arbiter_if #(.NREQ(4)) bus ();

    bus_arbiter #(.NREQ(4), .LOCK_MAX(LOCK_MAX)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;

    // Model: phase 0 = bus free, 1 = owner driving, 2 = destination loading.
    int ph, own, dsel, ptr, burst;
    int ack_log[$];
    int ack_cyc[$];

    function automatic integer z4(input logic [3:0] v);
        return {28'b0, v};
    endfunction

    function automatic integer z1(input logic v);
        return {31'b0, v};
    endfunction

    task automatic chk(input string name, input integer act, input integer exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, exp);
    endtask

    function automatic int pick(input logic [3:0] r, input int start);
        for (int k = 0; k < 4; k++)
            if (r[(start + k) % 4]) return (start + k) % 4;
        return -1;
    endfunction

    function automatic int dstv(input int i);
        return int'(bus.dst[2*i +: 2]);
    endfunction

    task automatic model_reset();
        ph = 0; own = 0; dsel = 0; ptr = 0; burst = 0;
    endtask

    task automatic grant(input int w);
        own = w; dsel = dstv(w); ph = 1; burst = 1;
    endtask

    task automatic model_adv();
        int w;
        case (ph)
            0: begin
                w = pick(bus.req, ptr);
                if (w >= 0) grant(w);
            end
            1: ph = 2;
            default: begin
                if (bus.lock[own] && bus.req[own] && burst < LOCK_MAX) begin
                    burst++;
                    dsel = dstv(own);
                    ph = 1;
                end else begin
                    ptr = (own + 1) % 4;
                    w = pick(bus.req, ptr);
                    if (w >= 0) grant(w);
                    else ph = 0;
                end
            end
        endcase
    endtask

    task automatic check_model();
        chk("xfer_en", z4(bus.xfer_en), (ph != 0) ? (1 << own) : 0);
        chk("load_en", z4(bus.load_en), (ph == 2) ? (1 << dsel) : 0);
        chk("ack", z4(bus.ack), (ph == 2) ? (1 << own) : 0);
        chk("busy", z1(bus.busy), (ph != 0) ? 1 : 0);
        if (ph != 0) chk("owner", {30'b0, bus.owner}, own);
        if (!reset) chk("owner_rst", {30'b0, bus.owner}, 0);
        chk("onehot0_xfer", z1($onehot0(bus.xfer_en)), 1);
        chk("onehot0_load", z1($onehot0(bus.load_en)), 1);
        chk("load_implies_ack", z1((bus.load_en == 4'b0) || (bus.ack != 4'b0)), 1);
        for (int i = 0; i < 4; i++)
            if (bus.ack[i] === 1'b1) begin
                ack_log.push_back(i);
                ack_cyc.push_back(cyc);
            end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_adv();
        cyc++;
        @(negedge clk);
        check_model();
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        model_reset();
        bus.req = '0;
        bus.lock = '0;
        cycle();
        reset = 1'b1;
        ack_log.delete();
        ack_cyc.delete();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (bus.busy && n < 20) begin
            cycle();
            n++;
        end
        chk(name, z1(bus.busy), 0);
    endtask

    task automatic run_acks(input int want, input int bound);
        int n = 0;
        while (ack_log.size() < want && n < bound) begin
            cycle();
            n++;
        end
        chk("ack_count", ack_log.size(), want);
    endtask

    initial begin
        int start;
        int exp_rr[5] = '{0, 1, 2, 3, 0};
        int exp_lk[4] = '{1, 1, 1, 2};
        logic [3:0] r, l;

        bus.req = '0;
        bus.lock = '0;
        bus.dst = '0;
        model_reset();
        repeat (2) cycle();
        chk("rst_busy", z1(bus.busy), 0);
        chk("rst_xfer", z4(bus.xfer_en), 'b0000);

        // Isolated transfer from requester 0 into register 2
        reset = 1'b1;
        bus.req = 4'b0001;
        bus.dst = 8'b0000_0010;
        cycle();
        chk("iso_drive_xfer", z4(bus.xfer_en), 'b0001);
        chk("iso_drive_load", z4(bus.load_en), 'b0000);
        cycle();
        chk("iso_load_load", z4(bus.load_en), 'b0100);
        chk("iso_load_ack", z4(bus.ack), 'b0001);
        bus.req = '0;
        cycle();
        chk("iso_idle_busy", z1(bus.busy), 0);

        // All requesting, no lock: fair rotation starting from 0
        reset_pulse();
        start = cyc;
        bus.req = 4'b1111;
        run_acks(5, 40);
        for (int k = 0; k < ack_log.size() && k < 5; k++) chk("rr_order", ack_log[k], exp_rr[k]);
        if (ack_cyc.size() > 0) chk("rr_first_lat", ack_cyc[0] - start, 2);
        for (int k = 1; k < ack_cyc.size() && k < 5; k++) chk("rr_spacing", ack_cyc[k] - ack_cyc[k-1], 2);
        bus.req = '0;
        wait_idle("rr_drain");

        // Locked burst by requester 1 capped at LOCK_MAX, then requester 2
        reset_pulse();
        bus.req = 4'b0110;
        bus.lock = 4'b0010;
        run_acks(4, 30);
        for (int k = 0; k < ack_log.size() && k < 4; k++) chk("lock_order", ack_log[k], exp_lk[k]);
        for (int k = 1; k < ack_cyc.size() && k < 4; k++) chk("lock_spacing", ack_cyc[k] - ack_cyc[k-1], 2);
        bus.req = '0;
        bus.lock = '0;
        wait_idle("lock_drain");

        // Destination changed after grant is ignored
        reset_pulse();
        bus.req = 4'b0010;
        bus.dst = 8'b0000_1000;
        cycle();
        bus.dst = 8'b0000_1100;
        cycle();
        chk("dst_latched", z4(bus.load_en), 'b0100);
        bus.req = '0;
        cycle();

        // Reset in DRIVE aborts immediately; requester 3 then gets a clean transfer
        reset_pulse();
        bus.req = 4'b0100;
        cycle();
        chk("abort_pre_busy", z1(bus.busy), 1);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("abort_xfer", z4(bus.xfer_en), 'b0000);
        chk("abort_busy", z1(bus.busy), 0);
        chk("abort_ack", z4(bus.ack), 'b0000);
        cycle();
        chk("abort_no_load", z4(bus.load_en), 'b0000);
        reset = 1'b1;
        bus.req = 4'b1000;
        cycle();
        chk("post_owner", {30'b0, bus.owner}, 3);
        chk("post_xfer", z4(bus.xfer_en), 'b1000);
        cycle();
        chk("post_ack", z4(bus.ack), 'b1000);
        bus.req = '0;
        cycle();
        chk("post_idle", z1(bus.busy), 0);

        // Randomized traffic with occasional asynchronous reset
        reset_pulse();
        for (int n = 0; n < 800; n++) begin
            r = bus.req;
            l = bus.lock;
            for (int i = 0; i < 4; i++) begin
                if (bus.ack[i]) begin
                    if (!(l[i] && $urandom_range(0, 1) == 1)) r[i] = 1'b0;
                end else if (!r[i] && $urandom_range(0, 3) == 0) r[i] = 1'b1;
                else if (r[i] && $urandom_range(0, 15) == 0) r[i] = 1'b0;
                if ($urandom_range(0, 7) == 0) l[i] = ~l[i];
            end
            bus.req = r;
            bus.lock = l;
            bus.dst = 8'($urandom);
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b0;
                model_reset();
                #1 check_model();
            end
            cycle();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
